// File: rtl/instr_mem_loader_if.sv
// Word stream into the instruction memory loader.
//   in_valid : source holds a word on in_data
//   in_data  : DW-bit machine word
//   in_ready : loader accepts the word this cycle
// master = word source, slave = loader.
interface instr_mem_loader_if #(
  parameter int DW = 9
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/instr_mem_loader.sv
// Write side of the instruction RAM (2**AW x DW) plus the core's fetch port.
// A load_start pulse captures a length (clamped to 2**AW); words arriving on
// the stream are written from address 0 upward. The core is held via
// cpu_hold until a complete image is in place.
//   clk, reset       : clock, async active-high reset
//   load_start/len   : begin a load of load_len words (ignored while loading)
//   in_if (slave)    : valid/ready word stream
//   pc / instr       : combinational fetch port, instr = mem[pc]
//   loading, done    : state is LOAD / DONE
//   cpu_hold         : core must stall (every state except DONE)
//   word_count       : words accepted in the current or last load
//   checksum         : XOR of those words
module instr_mem_loader #(
  parameter int AW = 8,
  parameter int DW = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_start,
  input  logic [AW:0]          load_len,
  instr_mem_loader_if.slave    in_if,
  input  logic [AW-1:0]        pc,
  output logic [DW-1:0]        instr,
  output logic                 loading,
  output logic                 done,
  output logic                 cpu_hold,
  output logic [AW:0]          word_count,
  output logic [DW-1:0]        checksum
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [AW:0] MAX_LEN = (AW+1)'(1 << AW);

  logic [1:0]    state;
  logic [AW:0]   len_q;
  logic [AW-1:0] ptr;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  logic          accept;
  logic [AW:0]   len_clamped;
  logic [AW:0]   wc_nxt;

  assign in_if.in_ready = (state == S_LOAD);
  assign loading        = (state == S_LOAD);
  assign done           = (state == S_DONE);
  assign cpu_hold       = (state != S_DONE);

  assign accept      = in_if.in_valid && in_if.in_ready;
  assign len_clamped = (load_len > MAX_LEN) ? MAX_LEN : load_len;
  assign wc_nxt      = word_count + (AW+1)'(1);

  // Control path. The pointer is AW bits; it would only wrap to 0 on the
  // edge that accepts word 2**AW, which is also the edge that leaves LOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      len_q      <= '0;
      ptr        <= '0;
      word_count <= '0;
      checksum   <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (accept) begin
            ptr        <= ptr + AW'(1);
            word_count <= wc_nxt;
            checksum   <= checksum ^ in_if.in_data;
            if (wc_nxt == len_q) state <= S_DONE;
          end
        end
        default: begin  // IDLE, DONE
          if (load_start) begin
            len_q      <= len_clamped;
            ptr        <= '0;
            word_count <= '0;
            checksum   <= '0;
            state      <= (len_clamped == '0) ? S_DONE : S_LOAD;
          end
        end
      endcase
    end
  end

  // RAM is deliberately outside reset: an aborted load keeps what it wrote.
  always_ff @(posedge clk) begin
    if (accept) mem[ptr] <= in_if.in_data;
  end

  // Read-before-write: a same-cycle write to pc shows up after the edge.
  assign instr = mem[pc];

endmodule
